// File: rtl/ls_fetch_sequencer.sv
// ls_fetch_sequencer
//   Fetch/decode/control sequencer for the load/store datapath. It fetches
//   instruction words over a req/ack handshake, decodes lwz/stw and steps the
//   datapath strobes one phase per cycle. It owns the PC.
//
//   Build option: LS_HALT_ON_ILLEGAL_EN
//     defined   - an undecodable opcode parks the FSM in HALT until rst
//     undefined - an undecodable opcode retires as a NOP (flag still set)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | one-cycle holdoff after reset
//   FETCH  | imem_req high at pc, waiting for imem_ack
//   DECODE | opcode of the latched instruction examined
//   EXEC   | ALU address settles, no strobes
//   MEM    | load: MemRead; store: MemWrite then retire
//   WB     | load only: MemRead + RegWrite, then retire
//   HALT   | parked after an illegal opcode (halt build only)
//
//   Every control output is a flop. Next values are computed from the next
//   state, so each strobe is high exactly while the FSM sits in its phase.

module ls_fetch_sequencer #(
  parameter int            N        = 32,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_data,
  input  logic         imem_ack,
  output logic [N-1:0] instruction,
  output logic [3:0]   ALU_OP,
  output logic         RegWrite,
  output logic         MemRead,
  output logic         MemWrite,
  output logic         XO,
  output logic [N-1:0] pc,
  output logic         illegal,
  output logic         retired
);

  localparam logic [5:0] OP_LWZ  = 6'b100000;
  localparam logic [5:0] OP_STW  = 6'b100100;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_NOP = 4'b0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [N-1:0] pc_d;
  logic [N-1:0] instr_d;
  logic [3:0]   alu_d;
  logic         xo_d;
  logic         ill_d;
  logic         req_d;
  logic         mem_rd_d;
  logic         mem_wr_d;
  logic         reg_wr_d;
  logic         ret_d;
  logic [5:0]   opcode;

  assign opcode    = instruction[31:26];
  // The fetch address is the PC register itself, no logic in between.
  assign imem_addr = pc;

  // Next-state and next-output computation; XO doubles as the load/store
  // selector once DECODE has passed, so no separate kind register is kept.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc;
    instr_d  = instruction;
    alu_d    = ALU_OP;
    xo_d     = XO;
    ill_d    = illegal;
    ret_d    = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        if (imem_ack && imem_req) begin
          instr_d = imem_data;
          state_d = DECODE;
        end
      end

      DECODE: begin
        case (opcode)
          OP_LWZ: begin
            xo_d    = 1'b0;
            alu_d   = ALU_ADD;
            state_d = EXEC;
          end
          OP_STW: begin
            xo_d    = 1'b1;
            alu_d   = ALU_ADD;
            state_d = EXEC;
          end
          default: begin
            xo_d    = 1'b0;
            alu_d   = ALU_NOP;
            ill_d   = 1'b1;
`ifdef LS_HALT_ON_ILLEGAL_EN
            state_d = HALT;
`else
            pc_d    = pc + N'(4);
            ret_d   = 1'b1;
            state_d = FETCH;
`endif
          end
        endcase
      end

      EXEC: begin
        state_d = MEM;
      end

      MEM: begin
        if (XO) begin
          pc_d    = pc + N'(4);
          ret_d   = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = WB;
        end
      end

      WB: begin
        pc_d    = pc + N'(4);
        ret_d   = 1'b1;
        state_d = FETCH;
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_d    = (state_d == FETCH);
    mem_rd_d = ((state_d == MEM) && !xo_d) || (state_d == WB);
    mem_wr_d = (state_d == MEM) && xo_d;
    reg_wr_d = (state_d == WB);
  end

  // State and all control outputs; enable low freezes every flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc          <= RESET_PC;
      instruction <= '0;
      ALU_OP      <= ALU_NOP;
      XO          <= 1'b0;
      illegal     <= 1'b0;
      imem_req    <= 1'b0;
      MemRead     <= 1'b0;
      MemWrite    <= 1'b0;
      RegWrite    <= 1'b0;
      retired     <= 1'b0;
    end else if (enable) begin
      state_q     <= state_d;
      pc          <= pc_d;
      instruction <= instr_d;
      ALU_OP      <= alu_d;
      XO          <= xo_d;
      illegal     <= ill_d;
      imem_req    <= req_d;
      MemRead     <= mem_rd_d;
      MemWrite    <= mem_wr_d;
      RegWrite    <= reg_wr_d;
      retired     <= ret_d;
    end
  end

endmodule

// File: tb/tb_ls_fetch_sequencer.sv
// Bench for ls_fetch_sequencer: table of instructions with their expected
// decode, expanded into per-cycle expectations on a scoreboard queue.
module tb_ls_fetch_sequencer;

  localparam logic [31:0] RPC = 32'h40;
  localparam logic [31:0] WPC = 32'hFFFFFFFC;
  localparam int K_LD  = 0;
  localparam int K_ST  = 1;
  localparam int K_ILL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        imem_ack;
  logic [31:0] imem_data;

  logic        imem_req, RegWrite, MemRead, MemWrite, XO, illegal, retired;
  logic [31:0] imem_addr, instruction, pc;
  logic [3:0]  ALU_OP;

  logic        imem_req_w, RegWrite_w, MemRead_w, MemWrite_w, XO_w, illegal_w, retired_w;
  logic [31:0] imem_addr_w, instruction_w, pc_w;
  logic [3:0]  ALU_OP_w;

  ls_fetch_sequencer #(.N(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_ack(imem_ack),
    .instruction(instruction), .ALU_OP(ALU_OP),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .XO(XO),
    .pc(pc), .illegal(illegal), .retired(retired)
  );

  // Second instance sees the same stimulus but starts at the top of memory.
  ls_fetch_sequencer #(.N(32), .RESET_PC(WPC)) dut_w (
    .clk(clk), .rst(rst), .enable(enable),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_data(imem_data), .imem_ack(imem_ack),
    .instruction(instruction_w), .ALU_OP(ALU_OP_w),
    .RegWrite(RegWrite_w), .MemRead(MemRead_w), .MemWrite(MemWrite_w), .XO(XO_w),
    .pc(pc_w), .illegal(illegal_w), .retired(retired_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          stall;
    int          frz;
    int          kind;
    logic        xo;
    logic [3:0]  alu;
  } vec_t;

  typedef struct {
    string       name;
    logic [5:0]  flags;   // req, mr, mw, rw, ret, ill
    logic [31:0] pc;
    logic [31:0] instr;
    logic        xo;
    logic [3:0]  alu;
    bit          care_dec;
    bit          care_xo;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [31:0] e_pc, e_instr;
  logic        e_xo, e_ill, e_ret;
  logic [3:0]  e_alu;
  bit          e_xo_known;

  exp_t       ce;
  logic [5:0] c_got, c_msk;
  bit         c_ok;

  // Pop one expectation per edge and compare it with the settled outputs.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      ce    = sb.pop_front();
      c_got = {imem_req, MemRead, MemWrite, RegWrite, retired, illegal};
      c_msk = ce.care_dec ? 6'b111111 : 6'b111110;
      c_ok  = ((c_got & c_msk) == (ce.flags & c_msk)) && (pc == ce.pc) &&
              (imem_addr == ce.pc) && (instruction == ce.instr) &&
              (!ce.care_dec || (ALU_OP == ce.alu)) &&
              (!(ce.care_dec && ce.care_xo) || (XO == ce.xo));
      n_vec++;
      if (!c_ok) begin
        n_bad++;
        $display("FAIL %s: got req/mr/mw/rw/ret/ill=%b pc=%h addr=%h instr=%h xo=%b alu=%h, want %b pc=%h instr=%h xo=%b alu=%h",
                 ce.name, c_got, pc, imem_addr, instruction, XO, ALU_OP,
                 ce.flags, ce.pc, ce.instr, ce.xo, ce.alu);
      end
    end
  end

  task automatic push(input string nm, input logic req, input logic mr,
                      input logic mw, input logic rw, input bit care_dec);
    exp_t e;
    e.name     = nm;
    e.flags    = {req, mr, mw, rw, e_ret, e_ill};
    e.pc       = e_pc;
    e.instr    = e_instr;
    e.xo       = e_xo;
    e.alu      = e_alu;
    e.care_dec = care_dec;
    e.care_xo  = e_xo_known;
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic en, input logic ack, input logic [31:0] d);
    rst       = r;
    enable    = en;
    imem_ack  = ack;
    imem_data = d;
    @(posedge clk);
    #2;
  endtask

  task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  // rst for the given edges, then one released edge: IDLE -> FETCH.
  task automatic do_reset(input int cycles, input logic ackv);
    e_pc = RPC; e_instr = '0; e_xo = 1'b0; e_alu = 4'h0;
    e_ill = 1'b0; e_ret = 1'b0; e_xo_known = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      push("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, ackv, $urandom);
    end
    push("idle_to_fetch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, ackv, $urandom);
  endtask

  // Runs one instruction starting from a visible FETCH cycle.
  task automatic do_instr(input vec_t v, input bit abort_in_mem);
    for (int i = 0; i < v.frz; i++) begin
      push({v.name, "_frozen"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, $urandom);
    end
    for (int i = 0; i < v.stall; i++) begin
      e_ret = 1'b0;
      push({v.name, "_stall"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, $urandom);
    end
    e_ret   = 1'b0;
    e_instr = v.instr;
    push({v.name, "_decode"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, v.instr);
    if (v.kind == K_ILL) begin
      e_ill = 1'b1; e_alu = 4'h0; e_xo_known = 1'b0;
`ifdef LS_HALT_ON_ILLEGAL_EN
      for (int i = 0; i < 3; i++) begin
        push({v.name, "_halt"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, $urandom);
      end
`else
      e_pc  = e_pc + 32'd4;
      e_ret = 1'b1;
      push({v.name, "_nop_retire"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, $urandom);
`endif
    end else begin
      e_xo = v.xo; e_alu = v.alu; e_xo_known = 1'b1;
      push({v.name, "_exec"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, $urandom);
      if (v.kind == K_LD) begin
        push({v.name, "_mem"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, $urandom);
        push({v.name, "_wb"}, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, $urandom);
        e_pc  = e_pc + 32'd4;
        e_ret = 1'b1;
        push({v.name, "_retire"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, $urandom);
      end else begin
        push({v.name, "_mem"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, $urandom);
        if (abort_in_mem) begin
          do_reset(1, 1'b0);
        end else begin
          e_pc  = e_pc + 32'd4;
          e_ret = 1'b1;
          push({v.name, "_retire"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
          step(1'b0, 1'b1, 1'b0, $urandom);
        end
      end
    end
  endtask

  vec_t vecs[7];
  vec_t extra;

  initial begin
    vecs[0] = '{"lwz_r1",     32'h80220001, 0, 0, K_LD,  1'b0, 4'h2};
    vecs[1] = '{"stw_r1",     32'h90240002, 0, 0, K_ST,  1'b1, 4'h2};
    vecs[2] = '{"lwz_stall3", 32'h8061FFF8, 3, 0, K_LD,  1'b0, 4'h2};
    vecs[3] = '{"stw_frz2",   32'h90A00010, 0, 2, K_ST,  1'b1, 4'h2};
    vecs[4] = '{"stw_stall1", 32'h93FF0000, 1, 0, K_ST,  1'b1, 4'h2};
    vecs[5] = '{"lwz_b2b",    32'h80000004, 0, 0, K_LD,  1'b0, 4'h2};
    vecs[6] = '{"illegal_fc", 32'hFC000000, 0, 0, K_ILL, 1'b0, 4'h0};

    rst = 1'b1; enable = 1'b1; imem_ack = 1'b1; imem_data = '0;
    do_reset(2, 1'b1);
    check32("wrap_pc_after_reset", pc_w, WPC);

    for (int i = 0; i < 7; i++) begin
      do_instr(vecs[i], 1'b0);
      if (i == 0) begin
        check32("wrap_pc_after_load", pc_w, 32'h0);
        check32("wrap_addr_after_load", imem_addr_w, 32'h0);
      end
    end

`ifndef LS_HALT_ON_ILLEGAL_EN
    extra = '{"illegal_near", 32'h84000000, 0, 0, K_ILL, 1'b0, 4'h0};
    do_instr(extra, 1'b0);
    extra = '{"lwz_after_ill", 32'h80400008, 0, 0, K_LD, 1'b0, 4'h2};
    do_instr(extra, 1'b0);
`endif

    do_reset(1, 1'b0);
    extra = '{"stw_abort", 32'h90240002, 0, 0, K_ST, 1'b1, 4'h2};
    do_instr(extra, 1'b1);
    extra = '{"lwz_post_abort", 32'h80220001, 0, 0, K_LD, 1'b0, 4'h2};
    do_instr(extra, 1'b0);

    step(1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ls_fetch_sequencer.md
# ls_fetch_sequencer

Multi-cycle fetch/decode/control sequencer that sits directly upstream of the load/store datapath. It fetches 32-bit uPower instructions from instruction memory over a req/ack handshake, decodes `lwz` and `stw`, and drives `instruction`, `ALU_OP`, `RegWrite`, `MemRead`, `MemWrite` and `XO` into the datapath, one phase per cycle. It owns the PC, advancing it by 4 after each retired instruction.

## Interface
- `N`, 32: instruction/PC width.
- `RESET_PC`, 32'h0: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: when 0, the FSM holds its state and all outputs keep their values.
- `imem_req` out 1: fetch request, high only in FETCH.
- `imem_addr` out N: byte address of the fetch, equal to `pc`.
- `imem_data` in N: instruction word, valid when `imem_ack`=1.
- `imem_ack` in 1: fetch completion; ignored unless `imem_req`=1.
- `instruction` out N: latched instruction to the datapath.
- `ALU_OP` out 4: 4'b0010 (add) for lwz/stw, else 4'b0000.
- `RegWrite`, `MemRead`, `MemWrite`, `XO` out 1 each: datapath controls.
- `pc` out N: current instruction address.
- `illegal` out 1: sticky flag, set on an undecodable opcode.
- `retired` out 1: one-cycle pulse when an instruction completes.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE → FETCH after one cycle.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`. On an edge with `imem_ack`=1, `instruction` is loaded from `imem_data` and the FSM goes to DECODE. Otherwise it stays in FETCH, with `imem_req` and the address held stable.
- DECODE: primary opcode is `instruction[31:26]`.
  - 6'b100000 (lwz): load.
  - 6'b100100 (stw): store.
  - Anything else is illegal.
  - `XO` is set here: 0 for load, 1 for store. It holds until the next DECODE.
  - `ALU_OP` is set here and held with the same lifetime as `XO`.
  - DECODE → EXEC.
- EXEC: no memory or register strobes; the ALU address settles. EXEC → MEM.
- MEM:
  - Load: `MemRead`=1, then → WB.
  - Store: `MemWrite`=1 for exactly this one cycle, then `pc` ← `pc`+4, `retired` pulses and the FSM goes → FETCH.
- WB (load only): `MemRead`=1 and `RegWrite`=1 for one cycle. Then `pc` ← `pc`+4, `retired` pulses and the FSM goes → FETCH.
- Illegal opcode: in DECODE, `illegal` is set (sticky until `rst`) and no strobe is raised. The next state depends on `LS_HALT_ON_ILLEGAL_EN` (see Configuration).
- Invariants:
  - `MemRead` and `MemWrite` are never both 1.
  - `RegWrite` is never 1 without `MemRead`=1.
  - All controls are registered outputs, with no combinational path from inputs to outputs.
- Arithmetic: `pc`+4 is modulo 2^N. `pc`=32'hFFFFFFFC wraps to 0 with no flag.

## Timing
- Reset values (edge with `rst`=1):
  - State = IDLE, `pc`=`RESET_PC`.
  - `instruction`=0, `ALU_OP`=0.
  - `RegWrite`=`MemRead`=`MemWrite`=`XO`=0.
  - `imem_req`=0, `illegal`=0, `retired`=0.
- `rst` dominates `enable`.
- Reset mid-instruction aborts it: `pc` does not advance and `retired` does not pulse. A `MemWrite`=1 already present during the cycle in which `rst` is sampled is still seen by the datapath at that edge. `MemWrite` is 0 from the next cycle onward.
- Latency, counted from the cycle after the `imem_ack` edge to the `retired` pulse:
  - Load: DECODE, EXEC, MEM, WB = 4 cycles. With ack on the first FETCH cycle, load throughput is 5 cycles per instruction.
  - Store: DECODE, EXEC, MEM = 3 cycles. Store throughput is 4 cycles per instruction.
- `enable`=0 freezes everything, including a raised `MemWrite`. The datapath will write again on each frozen edge, so the owner must deassert `enable` only in FETCH.
- An `imem_ack` arriving while `enable`=0 is ignored; the fetch completes on the first enabled edge that sees `imem_ack`=1.

## Configuration
- `LS_HALT_ON_ILLEGAL_EN`:
  - Defined: an illegal opcode sends DECODE → HALT. HALT keeps all strobes 0, `imem_req`=0 and `pc` frozen at the faulting address. Only `rst` exits HALT.
  - Undefined: an illegal opcode is treated as a NOP. DECODE → FETCH, `pc` ← `pc`+4, `retired` pulses, and `illegal` is still set.

## Test plan
- Reset/idle:
  - Stimulus: `rst`=1 for 2 cycles with `RESET_PC`=32'h40, then release, with `imem_ack` held high.
  - Response: all outputs 0 and `pc`=32'h40 during reset; `imem_req`=1 with `imem_addr`=32'h40 on the second cycle after release.
- Load sequence:
  - Stimulus: `imem_data`=32'h80220001 (lwz R1,1(R2)), ack immediate.
  - Response: `XO`=0 and `ALU_OP`=4'b0010 from DECODE; `MemRead`=1 for 2 cycles; `RegWrite`=1 only in the second; `retired` pulses; `pc` advances by 4; the next fetch starts 5 cycles after the previous one.
- Store sequence:
  - Stimulus: 32'h90240002 (stw R1,2(R4)).
  - Response: `XO`=1; `MemWrite`=1 for exactly 1 cycle; `RegWrite`=`MemRead`=0 throughout; 4-cycle throughput.
- Fetch stall:
  - Stimulus: `imem_ack` held low for 3 cycles.
  - Response: FSM stays in FETCH with `imem_req`/`imem_addr` stable; `instruction` is unchanged until the ack edge.
- Illegal opcode:
  - Stimulus: 32'hFC000000.
  - Response: `illegal`=1 and no strobes. With `LS_HALT_ON_ILLEGAL_EN` defined, `imem_req` stays 0 and `pc` is frozen. Without it, `pc`+4 and the next fetch proceeds.
- Reset in MEM of a store, plus wrap:
  - Stimulus: assert `rst` during the MEM cycle of a store.
  - Response: `MemWrite`=0 the following cycle; `pc`=`RESET_PC`; no `retired` pulse.
  - Separately, with `pc`=32'hFFFFFFFC a retired load wraps `pc` to 0.
